// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter and IF/ID pipeline register.
// Applies decode-stage redirects with one-delay-slot semantics; a redirect seen during a fetch miss is parked.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_flush,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic        j_taken,
  input  logic [31:0] j_pc,
  input  logic        jr_taken,
  input  logic [31:0] jr_pc,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_rdy,
  input  logic [31:0] if_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc8_D,
  output logic        valid_D
);

  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d;

  logic        redir;
  logic [31:0] target;

  // Redirects only count when D holds a real instruction.
  assign redir  = valid_q & (jr_taken | j_taken | br_taken);
  assign target = jr_taken ? jr_pc : (j_taken ? j_pc : br_pc);

  always_comb begin
    pc_d      = pc_q;
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    instr_d   = instr_q;
    pc8_d     = pc8_q;
    valid_d   = valid_q;
    if (exc_flush) begin
      pc_d     = EXC_VEC;
      pend_v_d = 1'b0;
      instr_d  = '0;
      valid_d  = 1'b0;
    end else if (!stall) begin
      if (if_rdy) begin
        // The word fetched now is the delay slot; it always enters D.
        instr_d  = if_rdata;
        pc8_d    = pc_q + 32'd8;
        valid_d  = 1'b1;
        pend_v_d = 1'b0;
        if (redir) begin
          pc_d = target;
        end else if (pend_v_q) begin
          pc_d = pend_pc_q;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end else begin
        instr_d = '0;
        valid_d = 1'b0;
        if (redir) begin
          pend_v_d  = 1'b1;
          pend_pc_d = target;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
      instr_q   <= '0;
      pc8_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
      instr_q   <= instr_d;
      pc8_q     <= pc8_d;
      valid_q   <= valid_d;
    end
  end

  assign if_req  = ~reset;
  assign if_addr = pc_q;
  assign instr_D = instr_q;
  assign pc8_D   = pc8_q;
  assign valid_D = valid_q;

endmodule
